uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `Uart8` transmitter among `NUM_REQ` byte producers. Each requester presents a byte with a level request. The arbiter grants one requester at a time, drives the `Uart8` tx handshake (`txStart`, `txByte`) and tracks `txBusy` and `txDone`. It reports per-requester completion and recovers from a stalled transmitter with a watchdog. It sits between the application logic and the `Uart8` tx port in the 12 MHz board design.

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one Uart8 transmitter among NUM_REQ byte producers,
// with per-byte completion pulses and a watchdog that abandons a stalled byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [8*NUM_REQ-1:0]         reqData,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         timeoutErr,
  output logic [$clog2(NUM_REQ)-1:0]   activeId,
  output logic                         txEn,
  output logic                         txStart,
  output logic [7:0]                   txByte,
  input  logic                         txBusy,
  input  logic                         txDone
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, SENDING, GAP} stateT;
  stateT state, stateNext;
  logic [IW-1:0] last, lastNext, idNext, pick, cand;
  logic [WW-1:0] wd, wdNext;
  logic [NUM_REQ-1:0] grantNext, doneNext;
  logic [7:0] byteNext;
  logic timeoutNext, startNext, found, expire, counting;
  int scan;
  // first requester after the one granted last, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    pick = '0;
    scan = 0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(last) + k) % NUM_REQ;
      cand = IW'(scan);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  assign counting = (state == LAUNCH) || (state == SENDING);
  assign expire = counting && (wd == WW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    stateNext = state;
    grantNext = '0;
    doneNext = '0;
    timeoutNext = 1'b0;
    startNext = txStart;
    byteNext = txByte;
    idNext = activeId;
    lastNext = last;
    wdNext = (counting && wd != WW'(TIMEOUT_CYCLES)) ? wd + WW'(1) : wd;
    case (state)
      IDLE: if (found) begin
        stateNext = LAUNCH;
        grantNext[pick] = 1'b1;
        byteNext = reqData[8*pick +: 8];
        idNext = pick;
        lastNext = pick;
        startNext = 1'b1;
        wdNext = '0;
      end
      LAUNCH: if (expire) begin
        stateNext = GAP;
        timeoutNext = 1'b1;
        startNext = 1'b0;
      end else if (txBusy) begin
        stateNext = SENDING;
        startNext = 1'b0;
      end
      // a completion on the expiry edge still counts as delivered
      SENDING: if (txDone) begin
        stateNext = GAP;
        doneNext[activeId] = 1'b1;
      end else if (expire) begin
        stateNext = GAP;
        timeoutNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      grant <= '0;
      done <= '0;
      timeoutErr <= 1'b0;
      txStart <= 1'b0;
      txEn <= 1'b0;
      txByte <= '0;
      activeId <= '0;
      last <= IW'(NUM_REQ - 1);
      wd <= '0;
    end else begin
      state <= stateNext;
      grant <= grantNext;
      done <= doneNext;
      timeoutErr <= timeoutNext;
      txStart <= startNext;
      txEn <= 1'b1;
      txByte <= byteNext;
      activeId <= idNext;
      last <= lastNext;
      wd <= wdNext;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized transactions against a round-robin/timing reference model,
// with a behavioural Uart8 tx responder driven from the bench.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 300;
  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] reqData = '0;
  logic [N-1:0] grant, done;
  logic timeoutErr, txEn, txStart;
  logic [$clog2(N)-1:0] activeId;
  logic [7:0] txByte;
  logic txBusy = 1'b0;
  logic txDone = 1'b0;
  int nChecks = 0;
  int nPass = 0;
  int lastRef = N - 1;
  int nextLat = 1;
  logic [7:0] bytes [N];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstN(rstN), .req(req), .reqData(reqData), .grant(grant), .done(done),
    .timeoutErr(timeoutErr), .activeId(activeId), .txEn(txEn), .txStart(txStart),
    .txByte(txByte), .txBusy(txBusy), .txDone(txDone)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic packData();
    for (int i = 0; i < N; i++) reqData[8*i +: 8] = bytes[i];
  endtask

  task automatic checkCleared(input string tag);
    check({tag, ".grant"}, 32'(grant), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".timeoutErr"}, 32'(timeoutErr), 0);
    check({tag, ".txStart"}, 32'(txStart), 0);
    check({tag, ".txEn"}, 32'(txEn), 0);
    check({tag, ".txByte"}, 32'(txByte), 0);
    check({tag, ".activeId"}, 32'(activeId), 0);
  endtask

  // next winner: scan last+1, last+2, ... modulo N
  function automatic int rrPick(input logic [N-1:0] mask);
    int r;
    r = -1;
    for (int k = N; k >= 1; k--) if (mask[(lastRef + k) % N]) r = (lastRef + k) % N;
    return r;
  endfunction

  // mode: 0 normal, 1 txDone on expiry edge, 2 never busy, 3 busy but no txDone, 4 reset mid-frame
  task automatic runByte(input logic [N-1:0] mask, input int mode);
    int exp, b, s, endR;
    logic hasDone, busyUsed;
    logic [7:0] expByte;
    req = mask;
    packData();
    exp = rrPick(mask);
    expByte = bytes[exp];
    lastRef = exp;
    for (int c = 1; c <= nextLat; c++) begin
      step();
      if (c < nextLat) check("grantEarly", 32'(grant), 0);
    end
    b = $urandom_range(0, 3);
    hasDone = (mode == 0) || (mode == 1) || (mode == 4);
    busyUsed = (mode != 2);
    s = (mode == 1) ? T - 1 : b + $urandom_range(2, 60);
    endR = hasDone ? s + 1 : T;
    for (int r = 0; r <= endR; r++) begin
      check("grant", 32'(grant), r == 0 ? 32'(1 << exp) : 0);
      check("txStart", 32'(txStart), busyUsed ? 32'(r <= b) : 32'(r < T));
      check("done", 32'(done), (hasDone && r == s + 1) ? 32'(1 << exp) : 0);
      check("timeoutErr", 32'(timeoutErr), 32'(!hasDone && r == T));
      check("txByte", 32'(txByte), 32'(expByte));
      check("activeId", 32'(activeId), 32'(exp));
      check("txEn", 32'(txEn), 1);
      if (mode == 4 && r == b + 2) begin
        rstN = 1'b0;
        #1;
        checkCleared("midReset");
        txBusy = 1'b0;
        txDone = 1'b0;
        step();
        step();
        checkCleared("heldReset");
        rstN = 1'b1;
        lastRef = N - 1;
        nextLat = 1;
        return;
      end
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) req = '0;
        reqData = $urandom;
      end
      txBusy = busyUsed && r >= b && (!hasDone || r <= s);
      txDone = hasDone && r == s;
      if (r < endR) step();
    end
    txBusy = 1'b0;
    txDone = 1'b0;
    nextLat = 2;
  endtask

  task automatic idleGap(input int k);
    req = '0;
    for (int i = 0; i < k; i++) begin
      step();
      check("idleGrant", 32'(grant), 0);
      check("idleDone", 32'(done), 0);
      check("idleTimeout", 32'(timeoutErr), 0);
    end
    nextLat = 1;
  endtask

  initial begin
    int mode;
    #2 rstN = 1'b0;
    step();
    step();
    checkCleared("reset");
    rstN = 1'b1;
    bytes[0] = 8'h56;
    runByte(4'b0001, 0);
    for (int i = 0; i < N; i++) bytes[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 5; i++) runByte(4'b1111, 0);
    runByte(4'b0100, 0);
    runByte(4'b0101, 0);
    runByte(4'b0101, 0);
    runByte(4'b0010, 2);
    runByte(4'b0010, 0);
    runByte(4'b1000, 3);
    runByte(4'b0110, 1);
    idleGap(3);
    runByte(4'b1111, 4);
    runByte(4'b1001, 0);
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
      mode = $urandom_range(0, 9);
      mode = mode < 7 ? 0 : mode - 6;
      if ($urandom_range(0, 3) == 0) idleGap($urandom_range(1, 4));
      runByte(4'($urandom_range(1, 15)), mode);
    end
    idleGap(2);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
